fwd_sel_ctrl: RTL and testbench

//  Generates registered 2-bit select codes for the two 32-bit mux_4 operand muxes in EX.

---
 rtl/fwd_sel_ctrl_pkg.sv | 19 +
 rtl/fwd_sel_ctrl_if.sv | 28 ++
 rtl/fwd_track_stage.sv | 25 ++
 rtl/fwd_sel_ctrl.sv | 96 +++++++++
 tb/tb_fwd_sel_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared operand-select encodings and tracker defaults for the EX forwarding controller.
// No logic; imported by the interface, tracker stage and top.
package fwd_sel_ctrl_pkg;

   localparam int RA_W_DEF     = 5;
   localparam int ZERO_REG_DEF = 0;

   // Control-bit widths of the tracker records; the address field adds RA_W on top.
   localparam int TRK_EX_CTL_W  = 3;  // valid, wr_en, is_load
   localparam int TRK_MEM_CTL_W = 2;  // valid, wr_en

   typedef enum logic [1:0] {
      SEL_RF    = 2'b00,
      SEL_EXMEM = 2'b01,
      SEL_MEMWB = 2'b10,
      SEL_IMM   = 2'b11
   } sel_e;

endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// Decode-to-forwarding-controller bundle: decoded instruction fields in, EX selects and stall out.
// Master is the decode side; slave is the forwarding controller.
interface fwd_sel_ctrl_if #(
   parameter int RA_W = fwd_sel_ctrl_pkg::RA_W_DEF
);
   logic            id_valid;
   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic            id_use_imm;
   logic [RA_W-1:0] id_rd;
   logic            id_wr_en;
   logic            id_is_load;
   logic            flush;
   logic [1:0]      sel_a;
   logic [1:0]      sel_b;
   logic            ex_valid;
   logic            stall;

   modport master (
      output id_valid, id_rs, id_rt, id_use_imm, id_rd, id_wr_en, id_is_load, flush,
      input  sel_a, sel_b, ex_valid, stall
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_imm, id_rd, id_wr_en, id_is_load, flush,
      output sel_a, sel_b, ex_valid, stall
   );
endinterface

// File: rtl/fwd_track_stage.sv
// One pipeline tracker register: reset and bubble clear the whole record, otherwise load when enabled.
// Latency one cycle; no backpressure of its own, the caller decides bubble/load.
module fwd_track_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bubble,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // An all-zero record is a bubble: valid=0, wr_en=0, is_load=0, rd=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (bubble) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// EX operand-mux select generation with EX/MEM destination tracking and load-use stall of decode.
// Selects are registered one cycle after issue; stall is combinational and holds decode for one cycle.
module fwd_sel_ctrl
   import fwd_sel_ctrl_pkg::*;
#(
   parameter int RA_W     = RA_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
) (
   input  logic          clk,
   input  logic          rst,
   fwd_sel_ctrl_if.slave io
);

   typedef struct packed {
      logic            valid;
      logic            wr_en;
      logic            is_load;
      logic [RA_W-1:0] rd;
   } ex_trk_t;

   typedef struct packed {
      logic            valid;
      logic            wr_en;
      logic [RA_W-1:0] rd;
   } mem_trk_t;

   localparam logic [RA_W-1:0] ZERO_ADDR = ZERO_REG[RA_W-1:0];

   ex_trk_t  ex_d, ex_q;
   mem_trk_t mem_d, mem_q;
   logic     hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
   logic     stall_c, issue;
   sel_e     sel_a_q, sel_b_q;

   function automatic logic stage_hits(input logic valid, input logic wr_en,
                                       input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r);
      return valid & wr_en & (rd == r) & (r != ZERO_ADDR);
   endfunction

   assign hit_ex_a  = stage_hits(ex_q.valid,  ex_q.wr_en,  ex_q.rd,  io.id_rs);
   assign hit_ex_b  = stage_hits(ex_q.valid,  ex_q.wr_en,  ex_q.rd,  io.id_rt);
   assign hit_mem_a = stage_hits(mem_q.valid, mem_q.wr_en, mem_q.rd, io.id_rs);
   assign hit_mem_b = stage_hits(mem_q.valid, mem_q.wr_en, mem_q.rd, io.id_rt);

   // A load in EX cannot forward yet; an immediate B operand does not depend on rt.
   assign stall_c = io.id_valid & ex_q.is_load & (hit_ex_a | (hit_ex_b & ~io.id_use_imm));
   assign issue   = io.id_valid & ~stall_c & ~io.flush;

   assign ex_d = '{valid: 1'b1, wr_en: io.id_wr_en, is_load: io.id_is_load, rd: io.id_rd};
   assign mem_d = '{valid: ex_q.valid, wr_en: ex_q.wr_en, rd: ex_q.rd};

   fwd_track_stage #(.W($bits(ex_trk_t))) u_ex_trk (
      .clk    (clk),
      .rst    (rst),
      .bubble (~issue),
      .en     (1'b1),
      .d      (ex_d),
      .q      (ex_q)
   );

   // MEM always takes the old EX record, so a stalled load keeps moving toward WB.
   fwd_track_stage #(.W($bits(mem_trk_t))) u_mem_trk (
      .clk    (clk),
      .rst    (rst),
      .bubble (1'b0),
      .en     (1'b1),
      .d      (mem_d),
      .q      (mem_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
      end else if (!issue) begin
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
      end else begin
         // Nearest producer wins: EX/MEM result is newer than MEM/WB.
         if (hit_ex_a)       sel_a_q <= SEL_EXMEM;
         else if (hit_mem_a) sel_a_q <= SEL_MEMWB;
         else                sel_a_q <= SEL_RF;

         if (io.id_use_imm)  sel_b_q <= SEL_IMM;
         else if (hit_ex_b)  sel_b_q <= SEL_EXMEM;
         else if (hit_mem_b) sel_b_q <= SEL_MEMWB;
         else                sel_b_q <= SEL_RF;
      end
   end

   assign io.sel_a    = sel_a_q;
   assign io.sel_b    = sel_b_q;
   assign io.ex_valid = ex_q.valid;
   assign io.stall    = stall_c;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: forwarding priority, load-use stall, zero register, immediate, flush and reset.
module tb_fwd_sel_ctrl;
   import fwd_sel_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fwd_sel_ctrl_if io ();

   fwd_sel_ctrl dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic imm,
                        input logic [4:0] rd, input logic wr, input logic ld);
      io.id_valid   = v;
      io.id_rs      = rs;
      io.id_rt      = rt;
      io.id_use_imm = imm;
      io.id_rd      = rd;
      io.id_wr_en   = wr;
      io.id_is_load = ld;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ex(input string tag, input logic v, input logic [1:0] a, input logic [1:0] b);
      check({tag, "_ex_valid"}, {31'd0, io.ex_valid}, {31'd0, v});
      check({tag, "_sel_a"}, {30'd0, io.sel_a}, {30'd0, a});
      check({tag, "_sel_b"}, {30'd0, io.sel_b}, {30'd0, b});
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      io.flush = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

      // Reset held two cycles with random decode traffic
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      check_ex("rst", 1'b0, 2'b00, 2'b00);
      check("rst_stall", {31'd0, io.stall}, 32'd0);
      rst = 1'b0;

      // EX/MEM then MEM/WB forwarding of r3
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
      tick();
      check_ex("add_r3", 1'b1, 2'b00, 2'b00);
      drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd8, 1'b1, 1'b0);
      check("use_r3_stall", {31'd0, io.stall}, 32'd0);
      tick();
      check_ex("use_r3_exmem", 1'b1, 2'b01, 2'b00);
      drive(1'b1, 5'd3, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      check_ex("use_r3_memwb", 1'b1, 2'b10, 2'b01);

      // Both stages write r5: the newer EX producer wins
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
      tick();
      check_ex("r5_nearest", 1'b1, 2'b01, 2'b01);

      // No instruction presented
      drive(1'b0, 5'd6, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      check_ex("idle", 1'b0, 2'b00, 2'b00);

      // Load r7 then dependent rt=7: one stall, then MEM/WB forward
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd1, 5'd7, 1'b0, 5'd10, 1'b1, 1'b0);
      check("lu_stall", {31'd0, io.stall}, 32'd1);
      tick();
      check_ex("lu_bubble", 1'b0, 2'b00, 2'b00);
      check("lu_retry_stall", {31'd0, io.stall}, 32'd0);
      tick();
      check_ex("lu_retry", 1'b1, 2'b00, 2'b10);

      // Zero register never forwarded; immediate overrides an rt match
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      tick();
      check_ex("zero_reg", 1'b1, 2'b00, 2'b00);
      drive(1'b1, 5'd0, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0);
      tick();
      check_ex("imm_b", 1'b1, 2'b00, 2'b11);

      // Load with immediate B matching rt must not stall
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd13, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0);
      check("lu_imm_nostall", {31'd0, io.stall}, 32'd0);
      tick();
      check_ex("lu_imm", 1'b1, 2'b00, 2'b11);

      // Flush during a load-use stall
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd7, 5'd2, 1'b0, 5'd14, 1'b1, 1'b0);
      io.flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, io.stall}, 32'd1);
      tick();
      io.flush = 1'b0;
      #1;
      check_ex("flush_bubble", 1'b0, 2'b00, 2'b00);
      check("flush_after_stall", {31'd0, io.stall}, 32'd0);

      // Reset mid-stall clears both trackers
      drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd7, 5'd2, 1'b0, 5'd15, 1'b1, 1'b0);
      check("pre_rst_stall", {31'd0, io.stall}, 32'd1);
      rst = 1'b1;
      tick();
      check("rst_mid_stall", {31'd0, io.stall}, 32'd0);
      check_ex("rst_mid", 1'b0, 2'b00, 2'b00);
      rst = 1'b0;
      tick();
      check_ex("post_rst_issue", 1'b1, 2'b00, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
